rcservo_ramp_ctrl: RTL and testbench



---
 rtl/rcservo_pkg.sv | 18 +
 rtl/rcservo_step_calc.sv | 20 ++
 rtl/rcservo_ramp_ctrl.sv | 125 ++++++++++++
 tb/tb_rcservo_ramp_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rcservo_pkg.sv
// rcservo_pkg: shared constants, register map and sequencer states for the servo ramp controller.
package rcservo_pkg;
    localparam int NCH_DEF       = 12;
    localparam int W_DEF         = 14;
    localparam int DIV_INIT_DEF  = 399;
    localparam int FREQ_INIT_DEF = 4999;

    localparam logic [4:0] HA_TGT0   = 5'd0;
    localparam logic [4:0] HA_CTRL   = 5'd12;
    localparam logic [4:0] HA_STATUS = 5'd13;
    localparam logic [4:0] HA_STEP0  = 5'd16;

    localparam logic [4:0] BA_DIV  = 5'd0;
    localparam logic [4:0] BA_FREQ = 5'd1;
    localparam logic [4:0] BA_CH0  = 5'd2;

    typedef enum logic [1:0] {INIT, IDLE, SCAN} stateT;
endpackage

// File: rtl/rcservo_step_calc.sv
// rcservo_step_calc: one frame's slew of a channel position toward its target.
module rcservo_step_calc
    import rcservo_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] Cur,
    input  logic [W-1:0] Tgt,
    input  logic [W-1:0] Step,
    output logic [W-1:0] Next
);
    logic         up;
    logic [W:0]   diff;

    assign up   = Tgt > Cur;
    assign diff = up ? {1'b0, Tgt} - {1'b0, Cur} : {1'b0, Cur} - {1'b0, Tgt};
    // An off servo, an off target or a zero step all jump straight to the target.
    assign Next = (Cur == '0 || Tgt == '0 || Step == '0 || diff <= {1'b0, Step}) ? Tgt
                : up ? Cur + Step : Cur - Step;
endmodule

// File: rtl/rcservo_ramp_ctrl.sv
// rcservo_ramp_ctrl: host-facing sequencer that initialises the servo PWM bank and
// slews every channel toward its target once per frame, one bank write per change.
module rcservo_ramp_ctrl
    import rcservo_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int W         = W_DEF,
    parameter int DIV_INIT  = DIV_INIT_DEF,
    parameter int FREQ_INIT = FREQ_INIT_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  Addr,
    input  logic [15:0] DataWr,
    output logic [15:0] DataRd,
    input  logic        En,
    input  logic        Wr,
    input  logic        FrameTick,
    output logic [4:0]  SAddr,
    output logic [15:0] SDataWr,
    output logic        SWr,
    output logic        SEn,
    output logic        Busy
);
    localparam int CW = $clog2(NCH);
    localparam int IW = $clog2(NCH + 3);

    stateT          state, stateNext;
    logic [IW-1:0]  initIdx;
    logic [CW-1:0]  ch;
    logic           run, pending;
    logic [W-1:0]   cur  [NCH];
    logic [W-1:0]   tgt  [NCH];
    logic [W-1:0]   step [NCH];
    logic [W-1:0]   nextPos;
    logic [NCH-1:0] atTarget;
    logic [4:0]     stepAddr;
    logic           hostWr, lastCh, sweepReq, sweepStart, tgtSel, stepSel;
    logic           unusedBits;

    assign hostWr     = Wr & En;
    assign lastCh     = ch == CW'(NCH - 1);
    assign sweepReq   = run & (FrameTick | pending);
    assign sweepStart = stateNext == SCAN && (state != SCAN || lastCh);
    assign tgtSel     = Addr < HA_TGT0 + 5'(NCH);
    assign stepAddr   = Addr - HA_STEP0;
    assign stepSel    = Addr >= HA_STEP0 && stepAddr < 5'(NCH);
    assign Busy       = state != IDLE;
    assign SEn        = SWr;
    assign unusedBits = &{1'b0, DataWr[15:W]};

    rcservo_step_calc #(.W(W)) uStepCalc (
        .Cur  (cur[ch]),
        .Tgt  (tgt[ch]),
        .Step (step[ch]),
        .Next (nextPos)
    );

    for (genvar g = 0; g < NCH; g++) begin : genAtTarget
        assign atTarget[g] = cur[g] == tgt[g];
    end

    assign DataRd = tgtSel            ? 16'(tgt[Addr[CW-1:0]])
                  : Addr == HA_CTRL   ? {15'd0, run}
                  : Addr == HA_STATUS ? {Busy, 15'(atTarget)}
                  : stepSel           ? 16'(step[stepAddr[CW-1:0]])
                  : 16'd0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= INIT;
        else state <= stateNext;
    end

    // INIT lingers one cycle after its last write so Busy covers the final strobe.
    always_comb begin
        stateNext = state;
        unique case (state)
            INIT:    stateNext = initIdx == IW'(NCH + 2) ? IDLE : INIT;
            IDLE:    stateNext = sweepReq ? SCAN : IDLE;
            SCAN:    stateNext = !lastCh || sweepReq ? SCAN : IDLE;
            default: stateNext = INIT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            initIdx <= '0;
            ch      <= '0;
            run     <= 1'b0;
            pending <= 1'b0;
            SWr     <= 1'b0;
            SAddr   <= '0;
            SDataWr <= '0;
            for (int i = 0; i < NCH; i++) begin
                cur[i]  <= '0;
                tgt[i]  <= '0;
                step[i] <= '0;
            end
        end else begin
            SWr     <= 1'b0;
            pending <= run && !sweepStart && (pending || (FrameTick && state != IDLE));
            if (hostWr && tgtSel) tgt[Addr[CW-1:0]] <= DataWr[W-1:0];
            if (hostWr && stepSel) step[stepAddr[CW-1:0]] <= DataWr[W-1:0];
            if (hostWr && Addr == HA_CTRL) run <= DataWr[0];
            if (state == INIT) begin
                initIdx <= initIdx + 1'b1;
                if (initIdx < IW'(NCH + 2)) begin
                    SWr     <= 1'b1;
                    SAddr   <= 5'(initIdx);
                    SDataWr <= initIdx == IW'(BA_DIV) ? 16'(DIV_INIT)
                             : initIdx == IW'(BA_FREQ) ? 16'(FREQ_INIT) : 16'd0;
                end
            end
            if (state == SCAN) begin
                ch <= lastCh ? '0 : ch + 1'b1;
                if (nextPos != cur[ch]) begin
                    cur[ch] <= nextPos;
                    SWr     <= 1'b1;
                    SAddr   <= BA_CH0 + 5'(ch);
                    SDataWr <= 16'(nextPos);
                end
            end
        end
    end
endmodule

// File: tb/tb_rcservo_ramp_ctrl.sv
// tb_rcservo_ramp_ctrl: table of per-frame target/step updates with expected bank writes,
// plus hand-written sequences for init, back-to-back sweeps, run-off and mid-sweep reset.
module tb_rcservo_ramp_ctrl;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  Addr = '0;
    logic [15:0] DataWr = '0;
    logic [15:0] DataRd;
    logic        En = 1'b0;
    logic        Wr = 1'b0;
    logic        FrameTick = 1'b0;
    logic [4:0]  SAddr;
    logic [15:0] SDataWr;
    logic        SWr, SEn, Busy;

    rcservo_ramp_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
        .En(En), .Wr(Wr), .FrameTick(FrameTick), .SAddr(SAddr), .SDataWr(SDataWr),
        .SWr(SWr), .SEn(SEn), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct { int cyc; int addr; int data; } wrT;
    typedef struct { int ch; int tgt; int step; int expCnt; int expData; int expMask; } vecT;

    int  cyc = 0;
    int  checks = 0;
    int  fails = 0;
    wrT  wrLog[$];
    bit  busyAt[int];
    vecT vecs[16];

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        busyAt[cyc] = Busy;
        if (SWr || SEn) begin
            checks++;
            if (SEn !== SWr) begin
                fails++;
                $display("FAIL sen_eq_swr cyc=%0d actual SEn=%b required SWr=%b", cyc, SEn, SWr);
            end
        end
        if (SWr === 1'b1) wrLog.push_back('{cyc, int'(SAddr), int'(SDataWr)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic checkRead(input string name, input int a, input int exp);
        Addr = 5'(a);
        #1;
        check(name, 32'(DataRd), exp);
    endtask

    task automatic hostWrite(input int a, input int d);
        Addr = 5'(a);
        DataWr = 16'(d);
        En = 1'b1;
        Wr = 1'b1;
        @(negedge Clk);
        En = 1'b0;
        Wr = 1'b0;
    endtask

    task automatic pulseTick(output int tc);
        FrameTick = 1'b1;
        tc = cyc;
        @(negedge Clk);
        FrameTick = 1'b0;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    task automatic checkInit();
        int r;
        wrLog.delete();
        Reset = 1'b0;
        r = cyc;
        waitUntil(r + 17);
        check("init_cnt", wrLog.size(), 14);
        for (int i = 0; i < wrLog.size() && i < 14; i++) begin
            check($sformatf("init%0d_cyc", i), wrLog[i].cyc - r, i + 1);
            check($sformatf("init%0d_addr", i), wrLog[i].addr, i);
            check($sformatf("init%0d_data", i), wrLog[i].data, i == 0 ? 399 : i == 1 ? 4999 : 0);
        end
        check("init_busy14", busyAt[r + 14], 1);
        check("init_busy15", busyAt[r + 15], 0);
    endtask

    initial begin
        int tc, t, x;
        vecs[0]  = '{0, 1500, 100, 1, 1500, 'hFFF};
        vecs[1]  = '{0, -1, -1, 0, 0, 'hFFF};
        vecs[2]  = '{3, 1500, 0, 1, 1500, 'hFFF};
        vecs[3]  = '{3, 1000, 300, 1, 1200, 'hFF7};
        vecs[4]  = '{3, -1, -1, 1, 1000, 'hFFF};
        vecs[5]  = '{5, 800, 10, 1, 800, 'hFFF};
        vecs[6]  = '{5, 0, -1, 1, 0, 'hFFF};
        vecs[7]  = '{1, 100, 0, 1, 100, 'hFFF};
        vecs[8]  = '{1, 1000, 250, 1, 350, 'hFFD};
        vecs[9]  = '{1, -1, -1, 1, 600, 'hFFD};
        vecs[10] = '{1, -1, -1, 1, 850, 'hFFD};
        vecs[11] = '{1, -1, -1, 1, 1000, 'hFFF};
        vecs[12] = '{1, 1300, 300, 1, 1300, 'hFFF};
        vecs[13] = '{2, 16383, 0, 1, 16383, 'hFFF};
        vecs[14] = '{2, 1, 16383, 1, 1, 'hFFF};
        vecs[15] = '{11, 4000, 0, 1, 4000, 'hFFF};

        repeat (3) @(negedge Clk);
        check("rst_swr", SWr, 0);
        check("rst_sen", SEn, 0);
        check("rst_saddr", SAddr, 0);
        check("rst_sdata", SDataWr, 0);
        check("rst_busy", Busy, 1);
        @(negedge Clk);
        checkInit();

        hostWrite(12, 1);
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].tgt >= 0) hostWrite(vecs[i].ch, vecs[i].tgt);
            if (vecs[i].step >= 0) hostWrite(16 + vecs[i].ch, vecs[i].step);
            wrLog.delete();
            pulseTick(tc);
            waitUntil(tc + 15);
            check($sformatf("v%0d_cnt", i), wrLog.size(), vecs[i].expCnt);
            if (vecs[i].expCnt > 0 && wrLog.size() > 0) begin
                check($sformatf("v%0d_addr", i), wrLog[0].addr, vecs[i].ch + 2);
                check($sformatf("v%0d_data", i), wrLog[0].data, vecs[i].expData);
                check($sformatf("v%0d_cyc", i), wrLog[0].cyc - tc, vecs[i].ch + 2);
            end
            check($sformatf("v%0d_busy_t1", i), busyAt[tc + 1], 1);
            check($sformatf("v%0d_busy_t13", i), busyAt[tc + 13], 0);
            checkRead($sformatf("v%0d_status", i), 13, vecs[i].expMask);
            @(negedge Clk);
        end

        checkRead("rd_t0", 0, 1500);
        checkRead("rd_t11", 11, 4000);
        checkRead("rd_s0", 16, 100);
        checkRead("rd_s1", 17, 300);
        checkRead("rd_s11", 27, 0);
        checkRead("rd_ctrl", 12, 1);
        checkRead("rd_a14", 14, 0);
        @(negedge Clk);
        hostWrite(14, 'hFFFF);
        checkRead("rd_a14_wr", 14, 0);
        checkRead("rd_a31", 31, 0);
        @(negedge Clk);

        hostWrite(1, 300);
        hostWrite(17, 100);
        wrLog.delete();
        pulseTick(t);
        waitUntil(t + 3);
        pulseTick(x);
        waitUntil(t + 6);
        pulseTick(x);
        waitUntil(t + 40);
        check("pend_cnt", wrLog.size(), 2);
        if (wrLog.size() >= 2) begin
            check("pend_w0_addr", wrLog[0].addr, 3);
            check("pend_w0_data", wrLog[0].data, 1200);
            check("pend_w0_cyc", wrLog[0].cyc - t, 3);
            check("pend_w1_data", wrLog[1].data, 1100);
            check("pend_w1_cyc", wrLog[1].cyc - t, 15);
        end
        check("pend_busy_t12", busyAt[t + 12], 1);
        check("pend_busy_t13", busyAt[t + 13], 1);
        check("pend_busy_t24", busyAt[t + 24], 1);
        check("pend_busy_t25", busyAt[t + 25], 0);

        hostWrite(12, 0);
        wrLog.delete();
        pulseTick(tc);
        waitUntil(tc + 15);
        check("norun_cnt", wrLog.size(), 0);
        check("norun_busy", busyAt[tc + 1], 0);
        hostWrite(12, 1);
        wrLog.delete();
        pulseTick(tc);
        waitUntil(tc + 15);
        check("rerun_cnt", wrLog.size(), 1);
        if (wrLog.size() > 0) check("rerun_data", wrLog[0].data, 1000);

        hostWrite(5, 700);
        wrLog.delete();
        pulseTick(t);
        waitUntil(t + 7);
        check("mid_pre_swr", SWr, 1);
        check("mid_pre_saddr", SAddr, 7);
        check("mid_pre_sdata", SDataWr, 700);
        Reset = 1'b1;
        #1;
        check("mid_rst_swr", SWr, 0);
        check("mid_rst_sen", SEn, 0);
        check("mid_rst_saddr", SAddr, 0);
        check("mid_rst_sdata", SDataWr, 0);
        check("mid_rst_busy", Busy, 1);
        @(negedge Clk);
        @(negedge Clk);
        checkInit();
        checkRead("post_status", 13, 'h0FFF);
        checkRead("post_ctrl", 12, 0);
        checkRead("post_t1", 1, 0);
        @(negedge Clk);
        hostWrite(1, 1100);
        checkRead("post_status_t1", 13, 'h0FFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
